// File: rtl/regfile_arbiter.sv
// Arbitrates the single register-file port between the CPU controller and a host debug port.
// Fixed CPU priority with host anti-starvation, plus an exclusive host lock that stalls the CPU.
module regfile_arbiter #(
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 8,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   input  logic              host_lock,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_locked,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [DATA_W-1:0] rf_rdata
);

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

   typedef enum logic {
      ST_SHARED,
      ST_LOCKED
   } state_t;

   state_t              state_reg;
   logic [CNT_W-1:0]    wait_cnt_reg;
   logic [CNT_W-1:0]    wait_cnt_next;
   logic                host_locked_reg;
   logic                cpu_rvalid_reg;
   logic                host_rvalid_reg;
   logic [DATA_W-1:0]   cpu_rdata_reg;
   logic [DATA_W-1:0]   host_rdata_reg;
   logic                host_prio;

   assign host_prio = (wait_cnt_reg == MAX_WAIT_C);

   // Grants are combinational so the access happens in the request cycle; reset masks them.
   always_comb begin
      cpu_gnt  = 1'b0;
      host_gnt = 1'b0;
      if (!reset) begin
         if (state_reg == ST_LOCKED) begin
            host_gnt = host_req;
         end else if (cpu_req && host_req) begin
            if (host_prio) host_gnt = 1'b1;
            else           cpu_gnt  = 1'b1;
         end else begin
            cpu_gnt  = cpu_req;
            host_gnt = host_req;
         end
      end
   end

   always_comb begin
      wait_cnt_next = wait_cnt_reg;
      if (host_gnt)
         wait_cnt_next = '0;
      else if (host_req && (wait_cnt_reg < MAX_WAIT_C))
         wait_cnt_next = wait_cnt_reg + 1'b1;
   end

   // AND-OR mux: grants are one-hot or zero, so no grant drives all-zero onto the port.
   assign rf_we = (cpu_gnt & cpu_we) | (host_gnt & host_we);

   genvar gi;
   generate
      for (gi = 0; gi < ADDR_W; gi++) begin : g_addr_mux
         assign rf_addr[gi] = (cpu_gnt & cpu_addr[gi]) | (host_gnt & host_addr[gi]);
      end
      for (gi = 0; gi < DATA_W; gi++) begin : g_wdata_mux
         assign rf_wdata[gi] = (cpu_gnt & cpu_wdata[gi]) | (host_gnt & host_wdata[gi]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_SHARED;
         host_locked_reg <= 1'b0;
         wait_cnt_reg    <= '0;
         cpu_rvalid_reg  <= 1'b0;
         host_rvalid_reg <= 1'b0;
         cpu_rdata_reg   <= '0;
         host_rdata_reg  <= '0;
      end else begin
         case (state_reg)
            ST_SHARED: begin
               if (host_lock) begin
                  state_reg       <= ST_LOCKED;
                  host_locked_reg <= 1'b1;
               end
            end
            ST_LOCKED: begin
               if (!host_lock) begin
                  state_reg       <= ST_SHARED;
                  host_locked_reg <= 1'b0;
               end
            end
            default: begin
               state_reg       <= ST_SHARED;
               host_locked_reg <= 1'b0;
            end
         endcase
         wait_cnt_reg    <= wait_cnt_next;
         cpu_rvalid_reg  <= cpu_gnt & ~cpu_we;
         host_rvalid_reg <= host_gnt & ~host_we;
         if (cpu_gnt && !cpu_we)   cpu_rdata_reg  <= rf_rdata;
         if (host_gnt && !host_we) host_rdata_reg <= rf_rdata;
      end
   end

   assign cpu_rvalid  = cpu_rvalid_reg;
   assign cpu_rdata   = cpu_rdata_reg;
   assign host_rvalid = host_rvalid_reg;
   assign host_rdata  = host_rdata_reg;
   assign host_locked = host_locked_reg;

endmodule
